// File: rtl/brg_pkg.sv
// Shared types and helpers for the baud-rate tick controller.
package brg_pkg;
  localparam int SEL_W  = 3;
  localparam int DCNT_W = 8;

  typedef enum logic [1:0] {RUN, PEND, SWITCH} brg_state_e;

  // The x8 divider counts 2^(sel+1) pre-ticks. The result needs one bit more
  // than DCNT_W so that sel=7 (256) is representable.
  function automatic logic [DCNT_W:0] x8_limit(input logic [SEL_W-1:0] sel);
    return (DCNT_W+1)'(1) << ({1'b0, sel} + 4'd1);
  endfunction
endpackage

// File: rtl/baud_div_counter.sv
// Generic mod-N counter. It counts 0..limit-1 on each advance and wraps.
// o_terminal is high combinationally on the advance that wraps the count.
module baud_div_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_clear,
  input  logic         i_advance,
  input  logic [W:0]   i_limit,
  output logic         o_terminal,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last     = ({1'b0, r_cnt} == (i_limit - (W+1)'(1)));
  assign o_terminal = i_advance & w_last;
  assign o_count    = r_cnt;

  // Clear has priority so that a switch can realign phase on any cycle.
  always_ff @(posedge i_clk) begin
    if (i_clear)        r_cnt <= '0;
    else if (i_advance) r_cnt <= w_last ? '0 : r_cnt + W'(1);
  end
endmodule

// File: rtl/baud_tick_ctrl.sv
// Runtime baud-rate controller: prescaler -> x8 divider -> oversample counter,
// emitting registered single-cycle tick enables. Baud changes are deferred
// until the frame logic is idle and then applied in a one-cycle SWITCH that
// clears the whole chain.
// Optional: define BRG_MIDTICK_EN to build the mid-bit strobe o_tick_mid.
module baud_tick_ctrl
  import brg_pkg::*;
#(
  parameter int               PRE_DIV     = 3,
  parameter int               OVERSAMPLE  = 8,
  parameter logic [SEL_W-1:0] DEFAULT_SEL = 3'd0
) (
  input  logic             i_fclk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_busy,
  input  logic             i_cfg_valid,
  input  logic [SEL_W-1:0] i_cfg_sel,
  output logic             o_cfg_ready,
  output logic             o_cfg_pending,
  output logic [SEL_W-1:0] o_cur_sel,
  output logic             o_tick_x8,
  output logic             o_tick_bit,
  output logic             o_tick_mid
);
  localparam int PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);

  brg_state_e       r_state;
  logic [SEL_W-1:0] r_cur_sel, r_nxt_sel;
  logic             r_cfg_ready, r_cfg_pending;
  logic             r_tick_x8, r_tick_bit;

  logic              w_clear, w_run, w_pre, w_x8_term, w_bit_term;
  logic [PW-1:0]     w_pcnt;
  logic [DCNT_W-1:0] w_dcnt;
  logic [SW-1:0]     w_scnt;

  // The chain freezes while disabled and during SWITCH, where it is cleared.
  assign w_clear = i_rst | (r_state == SWITCH);
  assign w_run   = i_en & (r_state != SWITCH);

  baud_div_counter #(.W(PW)) u_pcnt (
    .i_clk(i_fclk), .i_clear(w_clear), .i_advance(w_run),
    .i_limit((PW+1)'(PRE_DIV)), .o_terminal(w_pre), .o_count(w_pcnt)
  );

  baud_div_counter #(.W(DCNT_W)) u_dcnt (
    .i_clk(i_fclk), .i_clear(w_clear), .i_advance(w_pre),
    .i_limit(x8_limit(r_cur_sel)), .o_terminal(w_x8_term), .o_count(w_dcnt)
  );

  baud_div_counter #(.W(SW)) u_scnt (
    .i_clk(i_fclk), .i_clear(w_clear), .i_advance(w_x8_term),
    .i_limit((SW+1)'(OVERSAMPLE)), .o_terminal(w_bit_term), .o_count(w_scnt)
  );

  // Select handshake FSM; ready/pending are registered alongside the state.
  always_ff @(posedge i_fclk) begin
    if (i_rst) begin
      r_state       <= RUN;
      r_cur_sel     <= DEFAULT_SEL;
      r_nxt_sel     <= DEFAULT_SEL;
      r_cfg_ready   <= 1'b1;
      r_cfg_pending <= 1'b0;
    end else begin
      case (r_state)
        RUN: if (i_cfg_valid && r_cfg_ready) begin
          r_nxt_sel     <= i_cfg_sel;
          r_cfg_ready   <= 1'b0;
          r_cfg_pending <= 1'b1;
          r_state       <= i_busy ? PEND : SWITCH;
        end
        PEND: if (!i_busy) r_state <= SWITCH;
        SWITCH: begin
          r_cur_sel     <= r_nxt_sel;
          r_cfg_ready   <= 1'b1;
          r_cfg_pending <= 1'b0;
          r_state       <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Ticks fire the cycle after their terminal condition, for one cycle.
  always_ff @(posedge i_fclk) begin
    if (i_rst) begin
      r_tick_x8  <= 1'b0;
      r_tick_bit <= 1'b0;
    end else begin
      r_tick_x8  <= w_x8_term;
      r_tick_bit <= w_bit_term;
    end
  end

`ifdef BRG_MIDTICK_EN
  logic r_tick_mid;
  logic w_unused;
  assign w_unused = ^{w_pcnt, w_dcnt};

  // Mid strobe marks the x8 tick that moves scnt to OVERSAMPLE/2.
  always_ff @(posedge i_fclk) begin
    if (i_rst) r_tick_mid <= 1'b0;
    else       r_tick_mid <= w_x8_term & (w_scnt == SW'(OVERSAMPLE/2 - 1));
  end
  assign o_tick_mid = r_tick_mid;
`else
  logic w_unused;
  assign w_unused   = ^{w_pcnt, w_dcnt, w_scnt};
  assign o_tick_mid = 1'b0;
`endif

  assign o_cfg_ready   = r_cfg_ready;
  assign o_cfg_pending = r_cfg_pending;
  assign o_cur_sel     = r_cur_sel;
  assign o_tick_x8     = r_tick_x8;
  assign o_tick_bit    = r_tick_bit;
endmodule

// File: tb/tb_baud_tick_ctrl.sv
// Self-checking bench for baud_tick_ctrl. The reference tracks the number of
// enabled cycles since the last reset/switch and derives tick times from the
// period formulas. Honours BRG_MIDTICK_EN like the design.
module tb_baud_tick_ctrl;
  localparam int P  = 3;
  localparam int OS = 8;

  logic       fclk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, busy = 1'b0, cfg_valid = 1'b0;
  logic [2:0] cfg_sel = 3'd0;
  logic       cfg_ready, cfg_pending, tick_x8, tick_bit, tick_mid;
  logic [2:0] cur_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: 0 = run, 1 = waiting for idle, 2 = switching
  int m_st  = 0;
  int m_cur = 0;
  int m_nxt = 0;
  int m_ph  = 0;

  baud_tick_ctrl #(.PRE_DIV(P), .OVERSAMPLE(OS), .DEFAULT_SEL(3'd0)) dut (
    .i_fclk(fclk), .i_rst(rst), .i_en(en), .i_busy(busy),
    .i_cfg_valid(cfg_valid), .i_cfg_sel(cfg_sel),
    .o_cfg_ready(cfg_ready), .o_cfg_pending(cfg_pending), .o_cur_sel(cur_sel),
    .o_tick_x8(tick_x8), .o_tick_bit(tick_bit), .o_tick_mid(tick_mid)
  );

  always #5 fclk = ~fclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference, then check after the edge.
  task automatic cyc(input bit r, input bit e, input bit b, input bit v, input int s);
    int per;
    bit x8, bt, md;
    rst = r; en = e; busy = b; cfg_valid = v; cfg_sel = 3'(s);
    x8 = 0; bt = 0; md = 0;
    if (r) begin
      m_st = 0; m_cur = 0; m_ph = 0;
    end else if (m_st == 2) begin
      m_cur = m_nxt; m_ph = 0; m_st = 0;
    end else begin
      if (e) begin
        m_ph++;
        per = P * (2 ** (m_cur + 1));
        x8 = (m_ph % per) == 0;
        bt = (m_ph % (per * OS)) == 0;
        md = (m_ph % (per * OS)) == (per * OS / 2);
      end
      if (m_st == 0) begin
        if (v) begin m_nxt = s; m_st = b ? 1 : 2; end
      end else if (!b) m_st = 2;
    end
    @(posedge fclk); #1;
    chk("ready",   32'(cfg_ready),   32'(m_st == 0));
    chk("pending", 32'(cfg_pending), 32'(m_st != 0));
    chk("cur_sel", 32'(cur_sel),     32'(m_cur));
    chk("tick_x8", 32'(tick_x8),     32'(x8));
    chk("tick_bit",32'(tick_bit),    32'(bt));
`ifdef BRG_MIDTICK_EN
    chk("tick_mid",32'(tick_mid),    32'(md));
`else
    chk("tick_mid",32'(tick_mid),    32'(0));
`endif
  endtask

  initial begin
    int guard;
    bit b;
    // reset, then default select free-running
    repeat (2) cyc(1, 1, 0, 0, 0);
    repeat (150) cyc(0, 1, 0, 0, 0);
    // enable gap mid-period at sel 0
    repeat (2) cyc(0, 1, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);
    repeat (60) cyc(0, 1, 0, 0, 0);
    // accept landing on a bit-terminal cycle
    guard = 0;
    while (((m_ph + 1) % (P * 2 * OS)) != 0 && guard < 200) begin
      cyc(0, 1, 0, 0, 0); guard++;
    end
    chk("align_budget", 32'(guard < 200), 32'(1));
    cyc(0, 1, 0, 1, 1);
    repeat (100) cyc(0, 1, 0, 0, 0);
    // deferred change while busy
    cyc(0, 1, 1, 1, 2);
    repeat (100) cyc(0, 1, 1, 0, 0);
    repeat (120) cyc(0, 1, 0, 0, 0);
    // slowest select
    cyc(0, 1, 0, 1, 7);
    repeat (13000) cyc(0, 1, 0, 0, 0);
    // reset while a change is pending
    cyc(0, 1, 1, 1, 5);
    repeat (20) cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    repeat (100) cyc(0, 1, 0, 0, 0);
    // randomized traffic
    b = 0;
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 19) == 0) b = ~b;
      cyc(($urandom_range(0, 2999) == 0), ($urandom_range(0, 15) != 0), b,
          ($urandom_range(0, 49) == 0), $urandom_range(0, 4));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
